// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit for the memory-access step of a multicycle core.
// It accepts one load or store request and formats byte, half and word data. It runs a
// single access to data memory, which may insert wait states. It returns extended load
// data, a done pulse, or a fault pulse with a code.
//
// Handshake semantics (both sides):
//   - Request side: a request is taken on a rising edge where i_req_valid && o_req_ready.
//     o_req_ready is high only in IDLE. i_req_valid in any other state is ignored.
//   - Memory side: o_mem_valid is held high with o_mem_we/addr/wdata/be stable until the
//     first rising edge where i_mem_ready is high, or until the wait budget runs out.
//     i_mem_rdata is sampled on that same edge for loads.
module mem_access_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  i_req_valid,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  input  logic [2:0]            i_func_3,
  output logic                  o_req_ready,
  output logic                  o_done,
  output logic [31:0]           o_rdata,
  output logic                  o_fault,
  output logic [1:0]            o_fault_code,
  output logic                  o_mem_valid,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic [3:0]            o_mem_be,
  input  logic                  i_mem_ready,
  input  logic [31:0]           i_mem_rdata,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [1:0] FC_MISALIGNED = 2'b01;
  localparam logic [1:0] FC_ILLEGAL    = 2'b10;
  localparam logic [1:0] FC_TIMEOUT    = 2'b11;

  // Last wait-counter value before the access is abandoned.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [1:0]            r_state;
  logic [7:0]            r_cnt;
  logic [1:0]            r_off;
  logic [2:0]            r_func_3;
  logic                  r_done;
  logic                  r_fault;
  logic [1:0]            r_fault_code;
  logic [31:0]           r_rdata;
  logic                  r_mem_valid;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic [3:0]            r_mem_be;

  logic                  w_illegal;
  logic                  w_misaligned;
  logic [31:0]           w_st_wdata;
  logic [3:0]            w_st_be;
  logic [31:0]           w_shifted;
  logic [31:0]           w_ld_data;

  // Classify the incoming request: bad func_3 encoding, or address not aligned to size.
  always_comb begin
    w_illegal = 1'b0;
    if (i_req_write) begin
      w_illegal = !(i_func_3 == 3'b000 || i_func_3 == 3'b001 || i_func_3 == 3'b010);
    end else begin
      w_illegal = (i_func_3 == 3'b011 || i_func_3 == 3'b110 || i_func_3 == 3'b111);
    end
    w_misaligned = ((i_func_3[1:0] == 2'b01) && i_addr[0]) ||
                   ((i_func_3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
  end

  // Replicate store data across lanes and select the byte enables.
  always_comb begin
    w_st_wdata = i_wdata;
    w_st_be    = 4'b1111;
    if (i_req_write) begin
      case (i_func_3[1:0])
        2'b00: begin
          w_st_wdata = {4{i_wdata[7:0]}};
          w_st_be    = 4'b0001 << i_addr[1:0];
        end
        2'b01: begin
          w_st_wdata = {2{i_wdata[15:0]}};
          w_st_be    = i_addr[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          w_st_wdata = i_wdata;
          w_st_be    = 4'b1111;
        end
      endcase
    end
  end

  // Align the returned word to the addressed byte, then sign- or zero-extend.
  always_comb begin
    w_shifted = i_mem_rdata >> {r_off, 3'b000};
    case (r_func_3)
      3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
      3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
      default: w_ld_data = w_shifted;
    endcase
  end

  // Control FSM with request latching, wait-state counting, and result/fault registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_off        <= 2'd0;
      r_func_3     <= 3'd0;
      r_done       <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= 2'd0;
      r_rdata      <= 32'd0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_mem_be     <= 4'd0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            if (w_illegal) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_ILLEGAL;
            end else if (w_misaligned) begin
              r_fault      <= 1'b1;
              r_fault_code <= FC_MISALIGNED;
            end else begin
              r_off       <= i_addr[1:0];
              r_func_3    <= i_func_3;
              r_mem_we    <= i_req_write;
              r_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
              r_mem_wdata <= w_st_wdata;
              r_mem_be    <= w_st_be;
              r_mem_valid <= 1'b1;
              r_cnt       <= 8'd0;
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (i_mem_ready) begin
            if (!r_mem_we) begin
              r_rdata <= w_ld_data;
            end
            r_mem_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_cnt == TO_LAST) begin
            r_mem_valid  <= 1'b0;
            r_fault      <= 1'b1;
            r_fault_code <= FC_TIMEOUT;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready  = (r_state == S_IDLE);
  assign o_done       = r_done;
  assign o_rdata      = r_rdata;
  assign o_fault      = r_fault;
  assign o_fault_code = r_fault_code;
  assign o_mem_valid  = r_mem_valid;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_be     = r_mem_be;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed plus randomized checks of mem_access_unit against a
// byte-level memory and formatting model held in the bench.
module tb_mem_access_unit;

  // ---------------- clock / reset ----------------
  logic clk;
  logic arst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (default TIMEOUT) ----------------
  logic        i_req_valid, i_req_write;
  logic [31:0] i_addr, i_wdata;
  logic [2:0]  i_func_3;
  logic        o_req_ready, o_done, o_fault, o_mem_valid, o_mem_we;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wdata;
  logic [1:0]  o_fault_code, o_dbg_state;
  logic [3:0]  o_mem_be;
  logic        i_mem_ready;
  logic [31:0] i_mem_rdata;

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(255)) dut (
    .clk(clk), .arst(arst),
    .i_req_valid(i_req_valid), .i_req_write(i_req_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .i_func_3(i_func_3),
    .o_req_ready(o_req_ready), .o_done(o_done), .o_rdata(o_rdata),
    .o_fault(o_fault), .o_fault_code(o_fault_code),
    .o_mem_valid(o_mem_valid), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_ready(i_mem_ready), .i_mem_rdata(i_mem_rdata),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- timeout DUT (TIMEOUT = 4, memory never ready) ----------------
  logic        t_req_valid;
  logic        t_req_ready, t_done, t_fault, t_mem_valid, t_mem_we;
  logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
  logic [1:0]  t_fault_code, t_dbg_state;
  logic [3:0]  t_mem_be;

  mem_access_unit #(.ADDR_WIDTH(32), .TIMEOUT(4)) dut_to (
    .clk(clk), .arst(arst),
    .i_req_valid(t_req_valid), .i_req_write(1'b0), .i_addr(32'h0000_0010),
    .i_wdata(32'h0), .i_func_3(3'b010),
    .o_req_ready(t_req_ready), .o_done(t_done), .o_rdata(t_rdata),
    .o_fault(t_fault), .o_fault_code(t_fault_code),
    .o_mem_valid(t_mem_valid), .o_mem_we(t_mem_we), .o_mem_addr(t_mem_addr),
    .o_mem_wdata(t_mem_wdata), .o_mem_be(t_mem_be),
    .i_mem_ready(1'b0), .i_mem_rdata(32'hDEAD_BEEF),
    .o_dbg_state(t_dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata;
  logic [31:0] mem [16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  // 0 = legal, 1 = misaligned, 2 = illegal func_3
  function automatic int classify(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int size;
    bit legal;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal) return 2;
    size = (f3 == 3'd2) ? 4 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 1);
    if ((a % size) != 0) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] w);
    logic [31:0] sh, v;
    sh = w >> (8 * (a % 4));
    case (f3)
      3'd0: begin v = sh & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v - 65536; end
      3'd4: v = sh & 32'hFF;
      3'd5: v = sh & 32'hFFFF;
      default: v = sh;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [2:0] f3, input logic [31:0] a);
    if (!we) return 4'd15;
    case (f3)
      3'd0: return 4'(1 << (a % 4));
      3'd1: return 4'(3 << (a % 4));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
    case (f3)
      3'd0: return {24'd0, wd[7:0]} * 32'h0101_0101;
      3'd1: return {16'd0, wd[15:0]} * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  // ---------------- driver: one request, memory answers after 'waits' cycles ----------------
  task automatic run_op(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [2:0] f3, input int waits, input logic [31:0] rword);
    int          cls;
    logic [31:0] ea;
    logic [3:0]  be;
    logic [31:0] swd;
    cls = classify(we, f3, addr);
    ea  = {addr[31:2], 2'b00};
    be  = exp_be(we, f3, addr);
    swd = exp_wd(f3, wd);
    chk("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_write = we; i_addr = addr; i_wdata = wd; i_func_3 = f3;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    if (cls != 0) begin
      chk("fault_pulse", {31'd0, o_fault}, 32'd1);
      chk("fault_code", {30'd0, o_fault_code}, (cls == 2) ? 32'd2 : 32'd1);
      chk("fault_no_mem_valid", {31'd0, o_mem_valid}, 32'd0);
      chk("fault_ready", {31'd0, o_req_ready}, 32'd1);
      chk("fault_rdata_hold", o_rdata, last_rdata);
      @(posedge clk); #1;
      chk("fault_one_cycle", {31'd0, o_fault}, 32'd0);
      chk("fault_no_mem_valid2", {31'd0, o_mem_valid}, 32'd0);
    end else begin
      if (!we) exp_q.push_back(load_fmt(f3, addr, rword));
      for (int c = 0; c <= waits; c++) begin
        chk("mem_valid", {31'd0, o_mem_valid}, 32'd1);
        chk("mem_addr", o_mem_addr, ea);
        chk("mem_we", {31'd0, o_mem_we}, {31'd0, we});
        chk("mem_be", {28'd0, o_mem_be}, {28'd0, be});
        if (we) chk("mem_wdata", o_mem_wdata, swd);
        chk("no_early_done", {31'd0, o_done}, 32'd0);
        if (c == waits) begin
          i_req_valid = 1'b0;
          i_mem_ready = 1'b1;
          i_mem_rdata = rword;
        end else begin
          // Junk request traffic while busy must be ignored.
          i_req_valid = 1'($urandom_range(0, 1));
          i_addr      = $urandom;
          i_func_3    = 3'($urandom_range(0, 7));
          i_mem_ready = 1'b0;
          i_mem_rdata = $urandom;
        end
        @(posedge clk); #1;
      end
      i_mem_ready = 1'b0;
      i_req_valid = 1'b0;
      chk("done_pulse", {31'd0, o_done}, 32'd1);
      chk("done_mem_valid_low", {31'd0, o_mem_valid}, 32'd0);
      chk("done_no_fault", {31'd0, o_fault}, 32'd0);
      if (!we) last_rdata = exp_q.pop_front();
      else for (int i = 0; i < 4; i++) if (be[i]) mem[ea[5:2]][8*i +: 8] = swd[8*i +: 8];
      chk("rdata", o_rdata, last_rdata);
      @(posedge clk); #1;
      chk("done_one_cycle", {31'd0, o_done}, 32'd0);
      chk("ready_after_done", {31'd0, o_req_ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  int          nvalid, fault_k, ndone;
  logic [1:0]  fcode;
  logic        rwe;
  logic [2:0]  rf3;
  logic [31:0] raddr;
  logic [2:0]  ld_list [5];
  initial begin
    ld_list[0] = 3'd0; ld_list[1] = 3'd1; ld_list[2] = 3'd2; ld_list[3] = 3'd4; ld_list[4] = 3'd5;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    arst = 1'b1; i_req_valid = 1'b0; i_req_write = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
    i_func_3 = 3'd0; i_mem_ready = 1'b0; i_mem_rdata = 32'h0; t_req_valid = 1'b0;
    last_rdata = 32'h0;
    #1;
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_done", {31'd0, o_done}, 32'd0);
    chk("rst_fault", {31'd0, o_fault}, 32'd0);
    chk("rst_fault_code", {30'd0, o_fault_code}, 32'd0);
    chk("rst_mem_valid", {31'd0, o_mem_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, o_mem_we}, 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_mem_addr", o_mem_addr, 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_mem_be", {28'd0, o_mem_be}, 32'd0);
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    @(posedge clk); #1;

    // SB to the top byte lane, zero wait
    run_op(1'b1, 32'h0000_1003, 32'h0000_00A5, 3'd0, 0, 32'h0);
    // Byte/half loads with sign and zero extension
    run_op(1'b0, 32'h0000_2001, 32'h0, 3'd0, 0, 32'h1234_80FF);
    chk("lb_value", o_rdata, 32'hFFFF_FF80);
    run_op(1'b0, 32'h0000_2001, 32'h0, 3'd4, 1, 32'h1234_80FF);
    chk("lbu_value", o_rdata, 32'h0000_0080);
    run_op(1'b0, 32'h0000_2002, 32'h0, 3'd5, 2, 32'h1234_80FF);
    chk("lhu_value", o_rdata, 32'h0000_1234);
    // LW with five wait states
    run_op(1'b0, 32'h0000_3000, 32'h0, 3'd2, 5, 32'hCAFE_F00D);
    // Store must not disturb o_rdata
    run_op(1'b1, 32'h0000_3002, 32'h0000_BEEF, 3'd1, 1, 32'h0);
    chk("store_keeps_rdata", o_rdata, 32'hCAFE_F00D);
    // Faults
    run_op(1'b0, 32'h0000_4001, 32'h0, 3'd1, 0, 32'h0);
    run_op(1'b0, 32'h0000_4001, 32'h0, 3'd3, 0, 32'h0);
    run_op(1'b1, 32'h0000_4002, 32'h0, 3'd4, 0, 32'h0);
    run_op(1'b1, 32'h0000_4002, 32'h0, 3'd2, 0, 32'h0);

    // Reset in the middle of an access
    i_req_valid = 1'b1; i_req_write = 1'b0; i_addr = 32'h0000_0050; i_func_3 = 3'd2;
    @(posedge clk); #1;
    i_req_valid = 1'b0;
    chk("rstacc_valid_before", {31'd0, o_mem_valid}, 32'd1);
    @(posedge clk); #1;
    chk("rstacc_valid_held", {31'd0, o_mem_valid}, 32'd1);
    #2 arst = 1'b1;
    #1;
    chk("rstacc_valid_drop", {31'd0, o_mem_valid}, 32'd0);
    chk("rstacc_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rstacc_done", {31'd0, o_done}, 32'd0);
    @(posedge clk); #1 arst = 1'b0;
    last_rdata = 32'h0;
    i_mem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rstacc_no_done", {31'd0, o_done}, 32'd0);
      chk("rstacc_no_valid", {31'd0, o_mem_valid}, 32'd0);
    end
    i_mem_ready = 1'b0;

    // Timeout instance: memory never ready
    chk("to_ready", {31'd0, t_req_ready}, 32'd1);
    t_req_valid = 1'b1;
    nvalid = 0; fault_k = 0; ndone = 0; fcode = 2'd0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      t_req_valid = 1'b0;
      if (t_mem_valid) nvalid++;
      if (t_fault) begin fault_k = k; fcode = t_fault_code; end
      if (t_done) ndone++;
    end
    chk("to_valid_cycles", nvalid, 32'd4);
    chk("to_fault_cycle", fault_k, 32'd5);
    chk("to_fault_code", {30'd0, fcode}, 32'd3);
    chk("to_no_done", ndone, 32'd0);
    chk("to_rdata_kept", t_rdata, 32'd0);
    chk("to_ready_after", {31'd0, t_req_ready}, 32'd1);

    // Randomized traffic against the memory model
    for (int n = 0; n < 60; n++) begin
      rwe   = 1'($urandom_range(0, 1));
      raddr = 32'h0000_0100 + $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) rf3 = 3'($urandom_range(0, 7));
      else if (rwe) rf3 = 3'($urandom_range(0, 2));
      else rf3 = ld_list[$urandom_range(0, 4)];
      run_op(rwe, raddr, $urandom, rf3, $urandom_range(0, 3), mem[raddr[5:2]]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
